// File: rtl/tdc_stats.sv
// Window statistics for TDC measurements: mean/min/max over 2^LOG2_N samples with a valid/ready result port.
// Optional min/max tracking is built only when TDC_STATS_MINMAX_EN is defined.
module tdc_stats #(
  parameter int unsigned MEAS_W = 40,
  parameter int unsigned LOG2_N = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [MEAS_W-1:0] meas_in,
  input  logic              meas_valid,
  input  logic              clear,
  output logic [MEAS_W-1:0] stat_mean,
  output logic [MEAS_W-1:0] stat_min,
  output logic [MEAS_W-1:0] stat_max,
  output logic [7:0]        stat_drops,
  output logic              stat_valid,
  input  logic              stat_ready,
  output logic [LOG2_N:0]   sample_cnt,
  output logic              overrun
);

  localparam int unsigned SUM_W = MEAS_W + LOG2_N;
  localparam logic [LOG2_N:0] LAST_CNT = {1'b0, {LOG2_N{1'b1}}};

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t            state;
  logic [SUM_W-1:0]  sum;
  logic [SUM_W-1:0]  sum_next;
  logic              handshake;
  logic              accept;
  logic              last_sample;

  // In HOLD, sum and sample_cnt are already zero, so an accepted handshake-cycle
  // sample naturally becomes the first sample of the next window.
  always_comb begin
    sum_next    = sum + SUM_W'(meas_in);
    handshake   = (state == HOLD) && stat_ready;
    accept      = meas_valid && ((state == ACCUM) || handshake);
    last_sample = (state == ACCUM) && (sample_cnt == LAST_CNT);
  end

`ifdef TDC_STATS_MINMAX_EN
  logic [MEAS_W-1:0] run_min;
  logic [MEAS_W-1:0] run_max;
  logic [MEAS_W-1:0] min_next;
  logic [MEAS_W-1:0] max_next;
  logic              first_sample;

  always_comb begin
    first_sample = (sample_cnt == '0);
    min_next     = (first_sample || (meas_in < run_min)) ? meas_in : run_min;
    max_next     = (first_sample || (meas_in > run_max)) ? meas_in : run_max;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      run_min  <= '0;
      run_max  <= '0;
      stat_min <= '0;
      stat_max <= '0;
    end else if (accept) begin
      if (last_sample) begin
        stat_min <= min_next;
        stat_max <= max_next;
      end else begin
        run_min <= min_next;
        run_max <= max_next;
      end
    end
  end
`else
  assign stat_min = '0;
  assign stat_max = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state      <= ACCUM;
      sum        <= '0;
      sample_cnt <= '0;
      stat_mean  <= '0;
      stat_drops <= '0;
      stat_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (handshake) begin
        state      <= ACCUM;
        stat_valid <= 1'b0;
        stat_drops <= '0;
      end else if ((state == HOLD) && meas_valid) begin
        if (stat_drops != 8'hFF)
          stat_drops <= stat_drops + 8'd1;
        overrun <= 1'b1;
      end

      if (accept) begin
        if (last_sample) begin
          stat_mean  <= sum_next[SUM_W-1:LOG2_N];
          stat_valid <= 1'b1;
          state      <= HOLD;
          sum        <= '0;
          sample_cnt <= '0;
        end else begin
          sum        <= sum_next;
          sample_cnt <= sample_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tdc_stats.sv
// Directed bench for tdc_stats (MEAS_W=40, LOG2_N=4) with immediate-assertion checks.
module tb_tdc_stats;

  localparam int unsigned MEAS_W = 40;
  localparam int unsigned LOG2_N = 4;
`ifdef TDC_STATS_MINMAX_EN
  localparam bit MM = 1'b1;
`else
  localparam bit MM = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [MEAS_W-1:0] meas_in;
  logic              meas_valid;
  logic              clear;
  logic [MEAS_W-1:0] stat_mean;
  logic [MEAS_W-1:0] stat_min;
  logic [MEAS_W-1:0] stat_max;
  logic [7:0]        stat_drops;
  logic              stat_valid;
  logic              stat_ready;
  logic [LOG2_N:0]   sample_cnt;
  logic              overrun;

  int unsigned tests  = 0;
  int unsigned failed = 0;

  tdc_stats #(.MEAS_W(MEAS_W), .LOG2_N(LOG2_N)) dut (
    .clk        (clk),
    .rst        (rst),
    .meas_in    (meas_in),
    .meas_valid (meas_valid),
    .clear      (clear),
    .stat_mean  (stat_mean),
    .stat_min   (stat_min),
    .stat_max   (stat_max),
    .stat_drops (stat_drops),
    .stat_valid (stat_valid),
    .stat_ready (stat_ready),
    .sample_cnt (sample_cnt),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic feed(input logic [MEAS_W-1:0] v);
    meas_in    = v;
    meas_valid = 1'b1;
    tick();
    meas_valid = 1'b0;
  endtask

  function automatic logic [63:0] mm(input logic [63:0] v);
    return MM ? v : 64'd0;
  endfunction

  task automatic chk_result(input string tag, input logic [63:0] mean,
                            input logic [63:0] mn, input logic [63:0] mx);
    chk({tag, "_valid"}, 64'(stat_valid), 64'd1);
    chk({tag, "_mean"}, 64'(stat_mean), mean);
    chk({tag, "_min"}, 64'(stat_min), mm(mn));
    chk({tag, "_max"}, 64'(stat_max), mm(mx));
  endtask

  initial begin
    rst = 1'b1; meas_in = '0; meas_valid = 1'b0; clear = 1'b0; stat_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", 64'(stat_valid), 64'd0);
    chk("rst_mean", 64'(stat_mean), 64'd0);
    chk("rst_drops", 64'(stat_drops), 64'd0);
    chk("rst_cnt", 64'(sample_cnt), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);

    // Window 1: 0x100..0x10F back to back
    feed(40'h100);
    chk("w1_cnt1", 64'(sample_cnt), 64'd1);
    for (int i = 1; i < 15; i++) feed(40'(32'h100 + i));
    chk("w1_cnt15", 64'(sample_cnt), 64'd15);
    chk("w1_notvalid", 64'(stat_valid), 64'd0);
    feed(40'h10F);
    chk_result("w1", 64'h107, 64'h100, 64'h10F);
    chk("w1_drops", 64'(stat_drops), 64'd0);
    chk("w1_cnt0", 64'(sample_cnt), 64'd0);

    // Backpressure: three drops, result frozen
    for (int i = 0; i < 3; i++) feed(40'h999);
    chk("bp_drops", 64'(stat_drops), 64'd3);
    chk("bp_overrun", 64'(overrun), 64'd1);
    chk_result("bp", 64'h107, 64'h100, 64'h10F);
    chk("bp_cnt", 64'(sample_cnt), 64'd0);
    stat_ready = 1'b1;
    tick();
    stat_ready = 1'b0;
    chk("hs_valid", 64'(stat_valid), 64'd0);
    chk("hs_drops", 64'(stat_drops), 64'd0);
    chk("hs_overrun", 64'(overrun), 64'd1);

    // Window 2 then handshake colliding with a sample
    for (int i = 0; i < 16; i++) feed(40'h200);
    chk_result("w2", 64'h200, 64'h200, 64'h200);
    stat_ready = 1'b1;
    feed(40'h40);
    stat_ready = 1'b0;
    chk("col_valid", 64'(stat_valid), 64'd0);
    chk("col_drops", 64'(stat_drops), 64'd0);
    chk("col_cnt", 64'(sample_cnt), 64'd1);
    for (int i = 0; i < 15; i++) feed(40'h50);
    chk_result("w3", 64'h4F, 64'h40, 64'h50);

    // Clear in HOLD
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_valid", 64'(stat_valid), 64'd0);
    chk("clr_overrun", 64'(overrun), 64'd0);
    chk("clr_cnt", 64'(sample_cnt), 64'd0);

    // Clear mid-window beats a simultaneous sample
    for (int i = 0; i < 5; i++) feed(40'hFFF);
    chk("mid_cnt5", 64'(sample_cnt), 64'd5);
    clear = 1'b1;
    feed(40'hFFF);
    clear = 1'b0;
    chk("mid_clr_cnt", 64'(sample_cnt), 64'd0);
    for (int i = 1; i <= 16; i++) feed(40'(i * 16));
    chk_result("w4", 64'h88, 64'h10, 64'h100);

    // Drop counter saturation
    for (int i = 0; i < 257; i++) feed(40'h1);
    chk("sat_drops", 64'(stat_drops), 64'd255);
    chk("sat_overrun", 64'(overrun), 64'd1);
    chk_result("sat", 64'h88, 64'h10, 64'h100);
    stat_ready = 1'b1;
    tick();
    stat_ready = 1'b0;
    chk("sat_hs_drops", 64'(stat_drops), 64'd0);

    // Width extreme
    for (int i = 0; i < 16; i++) feed(40'hFF_FFFF_FFFF);
    chk_result("wide", 64'hFF_FFFF_FFFF, 64'hFF_FFFF_FFFF, 64'hFF_FFFF_FFFF);

    // Reset while holding a result
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rh_valid", 64'(stat_valid), 64'd0);
    chk("rh_mean", 64'(stat_mean), 64'd0);
    chk("rh_min", 64'(stat_min), 64'd0);
    chk("rh_max", 64'(stat_max), 64'd0);
    chk("rh_overrun", 64'(overrun), 64'd0);
    chk("rh_cnt", 64'(sample_cnt), 64'd0);
    for (int i = 0; i < 16; i++) feed(40'h80);
    chk_result("w5", 64'h80, 64'h80, 64'h80);
    chk("w5_drops", 64'(stat_drops), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/tdc_stats.md
# tdc_stats

Window statistics stage placed directly downstream of the TDC core. Consumes the 40-bit measurement word and its one-cycle valid pulse, then accumulates a fixed window of 2^LOG2_N samples. Per window it produces the truncated mean, minimum, maximum and a drop counter. Results are presented to the readout logic (UART formatter / LED display) over a valid/ready handshake.

## Interface
- MEAS_W, 40, measurement width: {6'b0, coarse[27:0], fine[5:0]}, treated as one unsigned integer
- LOG2_N, 4, window size exponent; window = 2^LOG2_N samples (legal 1..8)
- clk  in  1  100 MHz system clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- meas_in  in  MEAS_W  measurement word; sampled only when meas_valid=1
- meas_valid  in  1  one-cycle pulse per measurement
- clear  in  1  synchronous; discards the partial window and any pending result
- stat_mean  out  MEAS_W  sum >> LOG2_N, truncated
- stat_min  out  MEAS_W  smallest sample in window
- stat_max  out  MEAS_W  largest sample in window
- stat_drops  out  8  samples dropped while result pending; saturates at 255; cleared on handshake
- stat_valid  out  1  result available; held until accepted
- stat_ready  in  1  consumer accepts result when stat_valid & stat_ready
- sample_cnt  out  LOG2_N+1  samples accepted into the current window
- overrun  out  1  sticky; set on any drop; cleared only by rst or clear

## Operation
- Internal sum register SUM_W = MEAS_W+LOG2_N bits; it never overflows.
- States: ACCUM (stat_valid=0), HOLD (stat_valid=1).
- ACCUM, meas_valid=1: sum += meas_in and sample_cnt += 1.
  - First sample of a window (sample_cnt=0) loads both min and max with meas_in.
  - Later samples update min/max by unsigned compare.
- When the accepted sample is the 2^LOG2_N-th:
  - register stat_mean/min/max from the final values, including this sample;
  - go to HOLD;
  - reset sum and sample_cnt to 0.
- HOLD:
  - outputs stay frozen;
  - each meas_valid increments stat_drops (saturating) and sets overrun; the sample is discarded.
- HOLD, stat_valid & stat_ready: return to ACCUM next cycle and zero stat_drops.
  - A meas_valid in the same cycle is accepted as the first sample of the new window (sample_cnt=1 next cycle); it is not a drop.
- clear, any state:
  - next cycle state=ACCUM, sum=0, sample_cnt=0, stat_valid=0, stat_drops=0, overrun=0.
  - clear beats a simultaneous meas_valid (sample discarded) and a simultaneous handshake.
- rst: all outputs 0, state ACCUM, internal sum 0. Reset mid-window or mid-HOLD loses all data.

## Timing
- Accumulate latency: meas_valid at edge t shows in sample_cnt at t+1.
- Result latency: stat_valid rises at t+1 after the last sample at t; stat_mean/min/max are valid in the same cycle.
- Back-to-back meas_valid on consecutive cycles is supported at full rate in ACCUM.
- stat_valid deasserts the cycle after the handshake edge.
- stat_valid is never asserted together with stat_drops>0 before at least one drop has occurred in HOLD.
- Result registers only change on the HOLD entry edge, on clear, or on rst.

## Configuration
- TDC_STATS_MINMAX_EN defined:
  - min/max comparators and registers are built;
  - stat_min/stat_max behave as above.
- TDC_STATS_MINMAX_EN undefined:
  - no comparators or registers are built;
  - stat_min and stat_max are tied to 0;
  - mean, drops and handshake behaviour are unchanged.

## Test plan
- Minimum values, ready=1: 16 pulses with meas_in 0x100..0x10F -> stat_valid at cycle after 16th; mean=0x107, min=0x100, max=0x10F, drops=0.
- Backpressure: ready=0 after window full, 3 pulses -> stat_drops=3, overrun=1, results unchanged; ready=1 -> stat_valid=0 next cycle, drops=0, overrun stays 1.
- Handshake collision: handshake cycle with meas_valid=1 (meas_in 0x40) -> no drop; sample_cnt=1 next cycle; next window min=max candidate 0x40.
- Clear mid-window: 5 samples then clear together with meas_valid -> sample_cnt=0, sample not counted; next full window result excludes the first 5.
- Width extreme: 16 samples of 0xFF_FFFF_FFFF -> mean=0xFF_FFFF_FFFF, no wrap.
- Reset in HOLD: rst with stat_valid=1 -> all outputs 0 next cycle; fresh window of 16 × 0x80 -> mean=min=max=0x80.
